mux_arbiter_4: RTL and testbench

Round-robin arbiter that shares the registered 4:1 byte mux between four requesters. It drives the mux's 2-bit `select`, issues a one-hot grant to the owning requester, and bounds each ownership to a programmable number of cycles. It also produces `sample_valid`, aligned to the mux's one-cycle register latency, so downstream logic knows when the mux's 32-bit output `o` holds the granted source's zero-extended byte.

---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/rr_pick4.sv | 27 ++
 rtl/mux_arbiter_4.sv | 107 ++++++++++
 tb/tb_mux_arbiter_4.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NUM_SRC  = 4;
    localparam int SEL_W    = 2;
    localparam int HOLD_MAX = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first set request at or after ptr, wrapping mod 4.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    logic [SEL_W-1:0] cand;

    // Scan farthest offset first so the nearest hit to ptr overwrites it.
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arbiter_4.sv
// Round-robin owner of the registered 4:1 byte mux with bounded hold and a bubble after every release.
// Optional MUX_ARB_LOCK_EN adds a lock input that stretches ownership past the hold limit.
module mux_arbiter_4
    import mux_arb_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic               clock,
    input  logic               reset,
`ifdef MUX_ARB_LOCK_EN
    input  logic               lock,
`endif
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] grant,
    output logic [SEL_W-1:0]   select,
    output logic               busy,
    output logic               sample_valid
);

    arb_state_e         state_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_SRC-1:0] grant_q;
    logic [SEL_W-1:0]   select_q;
    logic               busy_q;
    logic               sample_valid_q;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic               lock_hold;
    logic               release_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [SEL_W-1:0]   ptr_d;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef MUX_ARB_LOCK_EN
    assign lock_hold = lock & req[owner_q];
`else
    assign lock_hold = 1'b0;
`endif

    // Owner drop and hold expiry collapse into one release, so ptr advances once.
    always_comb begin
        release_d = ~req[owner_q] | ((cnt_q == '0) & ~lock_hold);
        cnt_d     = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        ptr_d     = owner_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            owner_q        <= '0;
            cnt_q          <= '0;
            grant_q        <= '0;
            select_q       <= '0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= |grant_q;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q  <= GRANT;
                        owner_q  <= pick_idx;
                        grant_q  <= onehot(pick_idx);
                        select_q <= pick_idx;
                        busy_q   <= 1'b1;
                        cnt_q    <= CNT_W'(HOLD_CYCLES - 1);
                    end else begin
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant        = grant_q;
    assign select       = select_q;
    assign busy         = busy_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Directed bench for mux_arbiter_4: expected outputs queued per driven cycle, checked after each edge.
module tb_mux_arbiter_4;
    import mux_arb_pkg::*;

    localparam int HOLD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] select;
    logic       busy;
    logic       sample_valid;
`ifdef MUX_ARB_LOCK_EN
    logic       lock;
`endif

    always #5 clock = ~clock;

    mux_arbiter_4 #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
`ifdef MUX_ARB_LOCK_EN
        .lock         (lock),
`endif
        .req          (req),
        .grant        (grant),
        .select       (select),
        .busy         (busy),
        .sample_valid (sample_valid)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       b;
        logic       v;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_grant_exp = 1'b0;

    // Drive one cycle of inputs, queue what the outputs must be after the edge, then check.
    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] eg,
                        input logic [1:0] es, input string tag);
        exp_t e;
        exp_t x;
        reset = rst;
        req   = r;
        e.g   = eg;
        e.s   = es;
        e.b   = |eg;
        e.v   = rst ? 1'b0 : prev_grant_exp;
        prev_grant_exp = |eg;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        x = sb_q.pop_front();
        n_checks++;
        assert (grant === x.g) else begin
            n_fail++;
            $error("FAIL %s grant got=%b exp=%b", tag, grant, x.g);
        end
        n_checks++;
        assert (select === x.s) else begin
            n_fail++;
            $error("FAIL %s select got=%0d exp=%0d", tag, select, x.s);
        end
        n_checks++;
        assert (busy === x.b) else begin
            n_fail++;
            $error("FAIL %s busy got=%b exp=%b", tag, busy, x.b);
        end
        n_checks++;
        assert (sample_valid === x.v) else begin
            n_fail++;
            $error("FAIL %s sample_valid got=%b exp=%b", tag, sample_valid, x.v);
        end
    endtask

    // One full-length ownership of source idx followed by the mandatory idle bubble.
    task automatic own_block(input logic [1:0] idx, input logic [3:0] r, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        for (int i = 0; i < HOLD; i++) step(1'b0, r, oh, idx, tag);
        step(1'b0, r, 4'b0000, idx, {tag, "_bubble"});
    endtask

    initial begin
        logic [3:0] eg;
`ifdef MUX_ARB_LOCK_EN
        lock = 1'b0;
`endif
        step(1'b1, 4'b1111, 4'b0000, 2'd0, "reset0");
        step(1'b1, 4'b1111, 4'b0000, 2'd0, "reset1");

        for (int k = 0; k < 5; k++) own_block(2'(k % 4), 4'b1111, "rotate");

        own_block(2'd2, 4'b0100, "single_a");
        own_block(2'd2, 4'b0100, "single_b");

        step(1'b0, 4'b0010, 4'b0010, 2'd1, "early_g1");
        step(1'b0, 4'b1011, 4'b0010, 2'd1, "early_g2");
        step(1'b0, 4'b1001, 4'b0000, 2'd1, "early_rel");
        step(1'b0, 4'b1001, 4'b1000, 2'd3, "early_next");

        for (int i = 1; i <= 10; i++) begin
`ifdef MUX_ARB_LOCK_EN
            lock = (i < 10);
            eg   = (i < 10) ? 4'b1000 : 4'b0000;
`else
            eg   = ((i % 5) < 4 && i < 9) ? 4'b1000 : 4'b0000;
`endif
            step(1'b0, (i < 10) ? 4'b1000 : 4'b0000, eg, 2'd3, "lock_run");
        end
`ifdef MUX_ARB_LOCK_EN
        lock = 1'b0;
`endif

        step(1'b0, 4'b1010, 4'b0010, 2'd1, "rmg_g0");
        step(1'b0, 4'b1010, 4'b0010, 2'd1, "rmg_g1");
        step(1'b1, 4'b1010, 4'b0000, 2'd0, "rmg_reset");
        step(1'b0, 4'b1010, 4'b0010, 2'd1, "rmg_regrant");
        step(1'b0, 4'b0000, 4'b0000, 2'd1, "rmg_drop");
        step(1'b0, 4'b0000, 4'b0000, 2'd1, "rmg_idle");

        step(1'b0, 4'b0100, 4'b0100, 2'd2, "min_grant");
        step(1'b0, 4'b0000, 4'b0000, 2'd2, "min_release");
        step(1'b0, 4'b0000, 4'b0000, 2'd2, "min_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
